id_ex_stage: RTL and testbench

//  Decode->execute pipeline stage; consumes the two read ports of the general-purpose register file.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/operand_fwd_mux.sv | 30 +++
 rtl/id_ex_stage.sv | 73 +++++++
 tb/tb_id_ex_stage.sv | 114 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, control word type and forwarding-source encoding for the decode/execute slice.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int CTRL_W = 16;
  typedef logic [CTRL_W-1:0] ctrl_t;
  typedef enum logic [1:0] {FWD_RF, FWD_EXM, FWD_MWB, FWD_ZERO} fwd_sel_e;
endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: priority forwarding select for one source operand (MEM/WB path only with WB_BYPASS_EN).
module operand_fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [XLEN-1:0]  rdata,
  input  logic             exm_we,
  input  logic [REG_W-1:0] exm_rd,
  input  logic [XLEN-1:0]  exm_data,
  input  logic             mwb_we,
  input  logic [REG_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]  mwb_data,
  output logic [XLEN-1:0]  data
);
  fwd_sel_e sel;
  logic exm_hit, mwb_hit;
  assign exm_hit = exm_we && exm_rd == rs;
`ifdef WB_BYPASS_EN
  assign mwb_hit = mwb_we && mwb_rd == rs;
`else
  // Register file writes on negedge, so MEM/WB data already arrives on rdata.
  logic unused_mwb;
  assign unused_mwb = ^{mwb_we, mwb_rd, mwb_data};
  assign mwb_hit = 1'b0;
`endif
  always_comb begin
    sel = rs == '0 ? FWD_ZERO : exm_hit ? FWD_EXM : mwb_hit ? FWD_MWB : FWD_RF;
    data = sel == FWD_ZERO ? '0 : sel == FWD_EXM ? exm_data : sel == FWD_MWB ? mwb_data : rdata;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with operand forwarding and load-use stall; WB_BYPASS_EN adds MEM/WB forwarding.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic [REG_W-1:0] in_rd,
  input  logic [XLEN-1:0]  in_rdata1,
  input  logic [XLEN-1:0]  in_rdata2,
  input  logic [XLEN-1:0]  in_imm,
  input  ctrl_t            in_ctrl,
  input  logic             in_is_load,
  input  logic             exm_we,
  input  logic [REG_W-1:0] exm_rd,
  input  logic [XLEN-1:0]  exm_data,
  input  logic             mwb_we,
  input  logic [REG_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]  mwb_data,
  input  logic             flush,
  input  logic             hold_in,
  output logic             stall_out,
  output logic             out_valid,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2,
  output logic [REG_W-1:0] out_rd,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [XLEN-1:0]  out_imm,
  output ctrl_t            out_ctrl,
  output logic             out_is_load
);
  logic [XLEN-1:0] op1, op2;
  operand_fwd_mux u_fwd1 (.rs(in_rs1), .rdata(in_rdata1), .exm_we, .exm_rd, .exm_data,
                          .mwb_we, .mwb_rd, .mwb_data, .data(op1));
  operand_fwd_mux u_fwd2 (.rs(in_rs2), .rdata(in_rdata2), .exm_we, .exm_rd, .exm_data,
                          .mwb_we, .mwb_rd, .mwb_data, .data(op2));
  assign stall_out = out_valid && out_is_load && out_rd != '0 && in_valid &&
                     (out_rd == in_rs1 || out_rd == in_rs2);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_imm     <= '0;
      out_ctrl    <= '0;
      out_is_load <= 1'b0;
    end else if (hold_in) begin
`ifdef WB_BYPASS_EN
      // Frozen operands must still see writebacks that retire while EX is busy.
      if (mwb_we && mwb_rd != '0 && mwb_rd == out_rs1) out_op1 <= mwb_data;
      if (mwb_we && mwb_rd != '0 && mwb_rd == out_rs2) out_op2 <= mwb_data;
`endif
    end else if (flush || stall_out) begin
      out_valid <= 1'b0;
    end else begin
      out_valid   <= in_valid;
      out_rs1     <= in_rs1;
      out_rs2     <= in_rs2;
      out_rd      <= in_rd;
      out_op1     <= op1;
      out_op2     <= op2;
      out_imm     <= in_imm;
      out_ctrl    <= in_ctrl;
      out_is_load <= in_is_load;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
  import cpu_pkg::*;
  logic clk = 1'b0, rst, in_valid, in_is_load, exm_we, mwb_we, flush, hold_in;
  logic [REG_W-1:0] in_rs1, in_rs2, in_rd, exm_rd, mwb_rd;
  logic [XLEN-1:0] in_rdata1, in_rdata2, in_imm, exm_data, mwb_data;
  ctrl_t in_ctrl;
  logic stall_out, out_valid, out_is_load;
  logic [REG_W-1:0] out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0] out_op1, out_op2, out_imm;
  ctrl_t out_ctrl;
  int vecs = 0, miss = 0;
  always #5 clk = ~clk;
  id_ex_stage dut (.clk, .rst, .in_valid, .in_rs1, .in_rs2, .in_rd, .in_rdata1, .in_rdata2,
                   .in_imm, .in_ctrl, .in_is_load, .exm_we, .exm_rd, .exm_data, .mwb_we,
                   .mwb_rd, .mwb_data, .flush, .hold_in, .stall_out, .out_valid, .out_rs1,
                   .out_rs2, .out_rd, .out_op1, .out_op2, .out_imm, .out_ctrl, .out_is_load);
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; in_valid = 1; in_rs1 = 5; in_rs2 = 0; in_rd = 3; in_rdata1 = 32'hCAFE;
    in_rdata2 = 0; in_imm = 32'h7; in_ctrl = 16'hFFFF; in_is_load = 1; exm_we = 0; exm_rd = 0;
    exm_data = 0; mwb_we = 0; mwb_rd = 0; mwb_data = 0; flush = 0; hold_in = 0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_op1", out_op1, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_load", out_is_load, 0);
    chk("rst_stall", stall_out, 0);
    rst = 0; in_is_load = 0; in_rs1 = 5; in_rs2 = 9; in_rd = 8; in_rdata1 = 32'h11;
    in_rdata2 = 32'h22; in_imm = 32'h100; in_ctrl = 16'h1234;
    exm_we = 1; exm_rd = 5; exm_data = 32'hAAAA0000; mwb_we = 1; mwb_rd = 5; mwb_data = 32'h1;
    step();
    chk("exm_valid", out_valid, 1);
    chk("exm_prio_op1", out_op1, 32'hAAAA0000);
    chk("rf_op2", out_op2, 32'h22);
    chk("cap_rd", out_rd, 8);
    chk("cap_imm", out_imm, 32'h100);
    chk("cap_ctrl", out_ctrl, 16'h1234);
    exm_we = 0; mwb_rd = 9; mwb_data = 32'h99;
    step();
`ifdef WB_BYPASS_EN
    chk("mwb_op2", out_op2, 32'h99);
`else
    chk("mwb_op2", out_op2, 32'h22);
`endif
    chk("nofwd_op1", out_op1, 32'h11);
    in_rs1 = 1; in_rdata1 = 32'h77; in_rs2 = 0; in_rdata2 = 32'h1234;
    exm_we = 1; exm_rd = 0; exm_data = 32'hFFFFFFFF; mwb_we = 0;
    step();
    chk("r0_op2", out_op2, 0);
    chk("r0wr_op1", out_op1, 32'h77);
    exm_we = 0; in_is_load = 1; in_rd = 7; in_rs1 = 1; in_rs2 = 2;
    step();
    chk("load_flag", out_is_load, 1);
    in_is_load = 0; in_rs1 = 7; in_rs2 = 3; in_rd = 4; in_rdata1 = 32'hDEAD; in_rdata2 = 32'h33;
    #1;
    chk("lu_stall", stall_out, 1);
    step();
    chk("lu_bubble", out_valid, 0);
    chk("lu_stall_clr", stall_out, 0);
    exm_we = 1; exm_rd = 7; exm_data = 32'h55;
    step();
    chk("lu_valid", out_valid, 1);
    chk("lu_op1", out_op1, 32'h55);
    chk("lu_op2", out_op2, 32'h33);
    chk("lu_rd", out_rd, 4);
    exm_we = 0; in_is_load = 1; in_rd = 0; in_rs1 = 1; in_rs2 = 2;
    step();
    in_is_load = 0; in_rs1 = 0; in_rs2 = 0;
    #1;
    chk("load_r0_nostall", stall_out, 0);
    in_is_load = 1; in_rd = 7; in_rs1 = 1; in_rs2 = 2;
    step();
    in_is_load = 0; in_rs1 = 3; in_rs2 = 7; in_rd = 5; flush = 1;
    #1;
    chk("flush_stall", stall_out, 1);
    step();
    chk("flush_stall_valid", out_valid, 0);
    flush = 0; in_rs1 = 3; in_rdata1 = 32'h3333; in_rs2 = 4; in_rdata2 = 32'h4444; in_rd = 10;
    step();
    chk("cap2_valid", out_valid, 1);
    chk("cap2_op1", out_op1, 32'h3333);
    flush = 1; in_rd = 11;
    step();
    chk("flush_valid", out_valid, 0);
    flush = 0; in_rd = 10;
    step();
    flush = 1; hold_in = 1; in_rd = 12; in_rdata1 = 32'hBAD;
    step();
    chk("hold_valid", out_valid, 1);
    chk("hold_rd", out_rd, 10);
    chk("hold_op1", out_op1, 32'h3333);
`ifdef WB_BYPASS_EN
    flush = 0; mwb_we = 1; mwb_rd = 3; mwb_data = 32'h1234;
    step();
    chk("hold_refresh_op1", out_op1, 32'h1234);
    chk("hold_refresh_op2", out_op2, 32'h4444);
    chk("hold_refresh_rd", out_rd, 10);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
